// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port synchronous RAM shared between display
// scan-out (reserved phase-0 slot of every pixel) and a valid/ready pixel writer.
module vga_fb_arbiter #(
   parameter int DW       = 8,
   parameter int AW       = 15,
   parameter int SCALE    = 2,
   parameter int FB_DEPTH = (640 >> SCALE) * (480 >> SCALE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_in,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          video_on,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] pix_data,
   output logic          sync_err,
   output logic          oob_err
);

   localparam int          FB_W  = 640 >> SCALE;
   localparam logic [AW:0] DEPTH = (AW+1)'(FB_DEPTH);

   logic [1:0]    ph;
   logic          rd_issue;
   logic          rd_pend;
   logic          wr_acc;
   logic          wr_in_range;
   logic [AW-1:0] rd_addr;

   // Down-scaled frame-buffer address of the pixel currently being scanned.
   assign rd_addr = AW'(32'(pixel_y >> SCALE) * 32'(FB_W) + 32'(pixel_x >> SCALE));

   assign rd_issue    = ~rst & video_on & (ph == 2'd0);
   assign wr_ready    = ~rst & ((ph != 2'd0) | ~video_on);
   assign wr_acc      = wr_valid & wr_ready;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH;

   // NOTE: registers take non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph       <= 2'd0;
         sync_err <= 1'b0;
      end else if (tick_in) begin
         ph <= 2'd0;
         if (ph != 2'd3) sync_err <= 1'b1;
      end else begin
         ph <= ph + 2'd1;
      end
   end

   // The capture at the end of phase 1 always pairs with the read slot of the
   // phase 0 just before it, so writes granted in phase 1 cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         pix_data <= '0;
         oob_err  <= 1'b0;
      end else begin
         rd_pend <= rd_issue;
         if (ph == 2'd1) pix_data <= rd_pend ? mem_rdata : '0;
         if (wr_acc && !wr_in_range) oob_err <= 1'b1;
      end
   end

   // NOTE: every output gets a default before the branches, so no path through
   // this block leaves a signal unassigned and no latch is inferred.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rd_issue) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end else if (wr_acc && wr_in_range) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end
   end

   a_no_write_in_read_slot : assert property (
      @(posedge clk) disable iff (rst) !(rd_issue && mem_we));

   a_ready_excludes_read : assert property (
      @(posedge clk) disable iff (rst) !(rd_issue && wr_ready));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a behavioural RAM plus a pixel-level
// model of the arbitration rules, compared on every falling clock edge.
module tb_vga_fb_arbiter;

   localparam int DW    = 8;
   localparam int AW    = 15;
   localparam int UPS   = 4;      // up-scale factor (1 << SCALE)
   localparam int FBW   = 640 / UPS;
   localparam int DEPTH = 19200;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick_in = 1'b0;
   logic [9:0]    pixel_x = '0;
   logic [9:0]    pixel_y = '0;
   logic          video_on = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] pix_data;
   logic          sync_err;
   logic          oob_err;

   int checks   = 0;
   int failures = 0;
   bit auto_tick = 1'b0;

   vga_fb_arbiter dut (
      .clk(clk), .rst(rst), .tick_in(tick_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pix_data(pix_data), .sync_err(sync_err), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM driven by the DUT.
   logic [DW-1:0] ram [0:32767];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Model state: pixel phase, sticky flags, displayed word and an image of RAM.
   int            m_ph = 0;
   bit            m_sync = 1'b0;
   bit            m_oob = 1'b0;
   logic [DW-1:0] m_pix = '0;
   bit            m_pend = 1'b0;
   logic [DW-1:0] m_pend_val = '0;
   logic [DW-1:0] shadow [0:32767];

   function automatic int f_pix_addr();
      return ((int'(pixel_y) / UPS) * FBW + int'(pixel_x) / UPS) % 32768;
   endfunction

   function automatic bit f_ready();
      return !rst && (m_ph != 0 || !video_on);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph   <= 0;
         m_sync <= 1'b0;
         m_oob  <= 1'b0;
         m_pix  <= '0;
         m_pend <= 1'b0;
      end else begin
         if (m_ph == 0) begin
            m_pend     <= video_on;
            m_pend_val <= shadow[f_pix_addr()];
         end
         if (m_ph == 1) m_pix <= m_pend ? m_pend_val : '0;
         if (wr_valid && f_ready()) begin
            if (int'(wr_addr) < DEPTH) shadow[wr_addr] <= wr_data;
            else                       m_oob <= 1'b1;
         end
         if (tick_in) begin
            if (m_ph != 3) m_sync <= 1'b1;
            m_ph <= 0;
         end else begin
            m_ph <= (m_ph + 1) % 4;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      bit rd, rdy, wr;
      int e_addr;
      int e_wd;
      rd  = !rst && video_on && m_ph == 0;
      rdy = f_ready();
      wr  = wr_valid && rdy && int'(wr_addr) < DEPTH;
      e_addr = rd ? f_pix_addr() : (wr ? int'(wr_addr) : 0);
      e_wd   = wr ? int'(wr_data) : 0;
      check("wr_ready",  32'(wr_ready),  32'(rdy));
      check("mem_en",    32'(mem_en),    32'(rd || wr));
      check("mem_we",    32'(mem_we),    32'(wr));
      check("mem_addr",  32'(mem_addr),  32'(e_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      check("pix_data",  32'(pix_data),  32'(m_pix));
      check("sync_err",  32'(sync_err),  32'(m_sync));
      check("oob_err",   32'(oob_err),   32'(m_oob));
   end

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      tick_in = auto_tick && (m_ph == 3);
   endtask

   task automatic wait_ph(input int p);
      int n = 0;
      while (m_ph != p && n < 8) begin
         next_cycle();
         n++;
      end
   endtask

   task automatic burst(input int n, input int base, input int d, output int clks, output int bad);
      int acc = 0;
      bit got;
      clks = 0;
      bad  = 0;
      wr_valid = 1'b1;
      wr_addr  = 15'(base);
      wr_data  = 8'(d);
      while (acc < n && clks < 40) begin
         @(negedge clk);
         got = wr_ready;
         if (m_ph == 0 && video_on && mem_we) bad++;
         next_cycle();
         clks++;
         if (got) begin
            acc++;
            wr_addr = 15'(base + acc);
            wr_data = 8'(d + acc);
         end
      end
      wr_valid = 1'b0;
      check("burst_done", 32'(acc), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int clks, bad;
      logic [31:0] exp_rdy [0:4];
      exp_rdy[0] = 0; exp_rdy[1] = 1; exp_rdy[2] = 1; exp_rdy[3] = 1; exp_rdy[4] = 0;
      for (int i = 0; i < 32768; i++) begin
         ram[i]    = '0;
         shadow[i] = '0;
      end

      // Reset held while the writer requests.
      wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 8'h55;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("rst_wr_ready", 32'(wr_ready), 0);
      check("rst_mem_en",   32'(mem_en),   0);
      check("rst_mem_we",   32'(mem_we),   0);
      check("rst_pix_data", 32'(pix_data), 0);
      next_cycle();
      rst = 1'b0; wr_valid = 1'b0; video_on = 1'b1;
      // Phase runs 0,1,2,3,0: only phase 0 withholds the writer in active video.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ph_seq_ready", 32'(wr_ready), exp_rdy[i]);
         next_cycle();
      end

      // Blanking: four back-to-back writes to words 0..3.
      video_on = 1'b0;
      burst(4, 0, 8'hA4, clks, bad);
      check("blank_clks", 32'(clks), 4);
      repeat (4) next_cycle();
      @(negedge clk);
      check("blank_pix", 32'(pix_data), 0);
      next_cycle();

      // Display read of pixel (4,0) -> word 1.
      auto_tick = 1'b1;
      pixel_x = 10'd4; pixel_y = 10'd0; video_on = 1'b1;
      wait_ph(0);
      @(negedge clk);
      check("rd_en",   32'(mem_en),   1);
      check("rd_we",   32'(mem_we),   0);
      check("rd_addr", 32'(mem_addr), 1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("pix_ph2", 32'(pix_data), 32'h A5);
      next_cycle();
      @(negedge clk);
      check("pix_ph3", 32'(pix_data), 32'h A5);
      next_cycle();

      // Active video: eight writes starting in phase 1.
      wait_ph(1);
      burst(8, 320, 8'h10, clks, bad);
      check("active_clks", 32'(clks), 10);
      check("active_ph0_we", 32'(bad), 0);

      // Scan row y=8 across x=0..31 (words 320..327).
      pixel_y = 10'd8;
      for (int x = 0; x < 32; x++) begin
         wait_ph(0);
         pixel_x = 10'(x);
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (x == 12 && j == 2) check("scan_x12", 32'(pix_data), 32'h13);
            next_cycle();
         end
      end

      // Range boundary: last legal word, then first illegal one.
      video_on = 1'b0;
      wr_valid = 1'b1; wr_addr = 15'd19199; wr_data = 8'h77;
      @(negedge clk);
      check("last_word_en",   32'(mem_en),   1);
      check("last_word_addr", 32'(mem_addr), 19199);
      next_cycle();
      wr_addr = 15'd19200;
      @(negedge clk);
      check("oob_ready", 32'(wr_ready), 1);
      check("oob_en",    32'(mem_en),   0);
      next_cycle();
      wr_valid = 1'b0;
      @(negedge clk);
      check("oob_flag", 32'(oob_err), 1);
      next_cycle();

      // Out-of-phase tick at phase 1.
      auto_tick = 1'b0;
      video_on = 1'b1;
      wait_ph(1);
      tick_in = 1'b1;
      @(negedge clk);
      check("sync_before", 32'(sync_err), 0);
      next_cycle();
      @(negedge clk);
      check("tick_ph0_ready", 32'(wr_ready), 0);
      check("sync_set",       32'(sync_err), 1);
      next_cycle();
      auto_tick = 1'b1;
      repeat (12) next_cycle();
      @(negedge clk);
      check("sync_sticky", 32'(sync_err), 1);
      check("oob_sticky",  32'(oob_err),  1);
      next_cycle();

      // Reset mid-write takes effect combinationally.
      video_on = 1'b0;
      wr_valid = 1'b1; wr_addr = 15'd9; wr_data = 8'h99;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(wr_ready), 0);
      check("midrst_en",    32'(mem_en),   0);
      check("midrst_we",    32'(mem_we),   0);
      check("midrst_sync",  32'(sync_err), 0);
      check("midrst_oob",   32'(oob_err),  0);
      next_cycle();
      rst = 1'b0; wr_valid = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      check("post_rst_oob", 32'(oob_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
